mem_stage: RTL and testbench

//  Memory-access stage between the EX/MEM pipeline register and the MEM/WB register.
//  It issues loads and stores to a variable-latency data memory using a req/ack handshake.

---
 rtl/mem_stage.sv | 147 ++++++++++++++
 tb/tb_mem_stage.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access stage: issues loads/stores over a req/ack handshake, stalls upstream while busy.
// Optional macro ALIGN_CHECK_EN: odd addresses abort straight to DONE with an error.
module mem_stage #(
   parameter int DATA_W  = 16,
   parameter int REG_W   = 3,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid,
   input  logic [DATA_W-1:0] ALUData,
   input  logic [DATA_W-1:0] wrData,
   input  logic              memRead,
   input  logic              memWrite,
   input  logic              memToReg,
   input  logic              regWrite,
   input  logic [REG_W-1:0]  writeReg,
   output logic              stall,
   output logic              outValid,
   output logic [DATA_W-1:0] memData,
   output logic [DATA_W-1:0] ALUDataOut,
   output logic              memToRegOut,
   output logic              regWriteOut,
   output logic [REG_W-1:0]  writeRegOut,
   output logic              memErr,
   output logic              memReq,
   output logic              memWe,
   output logic [DATA_W-1:0] memAddr,
   output logic [DATA_W-1:0] memWData,
   input  logic              memAck,
   input  logic [DATA_W-1:0] memRData
);
   // state | meaning
   // IDLE  | no access in flight; non-memory ops pass straight through
   // REQ   | memReq held high until memAck or timeout
   // DONE  | one-cycle result presentation to MEM/WB
   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

   localparam int CNT_W = $clog2(TIMEOUT) + 1;

   state_t            state, state_nx;
   logic [CNT_W-1:0]  cnt;
   logic [DATA_W-1:0] hold_addr, hold_wdata, hold_data;
   logic [REG_W-1:0]  hold_wreg;
   logic              hold_rd, hold_wr, hold_m2r, hold_rw, err_hold;
   logic              mem_op, misalign, timeout_hit;

   assign mem_op      = valid & (memRead | memWrite);
   assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));
`ifdef ALIGN_CHECK_EN
   assign misalign = ALUData[0];
`else
   assign misalign = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt        <= '0;
         hold_addr  <= '0;
         hold_wdata <= '0;
         hold_data  <= '0;
         hold_wreg  <= '0;
         hold_rd    <= 1'b0;
         hold_wr    <= 1'b0;
         hold_m2r   <= 1'b0;
         hold_rw    <= 1'b0;
         err_hold   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (mem_op) begin
               cnt        <= '0;
               hold_addr  <= ALUData;
               hold_wdata <= wrData;
               hold_data  <= '0;
               hold_wreg  <= writeReg;
               hold_rd    <= memRead;
               hold_wr    <= memWrite;
               hold_m2r   <= memToReg;
               hold_rw    <= regWrite;
               err_hold   <= misalign;
            end
            REQ: begin
               // ack beats a simultaneous timeout
               if (memAck) begin
                  if (hold_rd) hold_data <= memRData;
               end else if (timeout_hit) begin
                  err_hold <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nx    = state;
      stall       = 1'b0;
      outValid    = 1'b0;
      memData     = '0;
      ALUDataOut  = ALUData;
      memToRegOut = memToReg;
      regWriteOut = regWrite;
      writeRegOut = writeReg;
      memErr      = 1'b0;
      memReq      = 1'b0;
      memWe       = 1'b0;
      memAddr     = '0;
      memWData    = '0;
      case (state)
         IDLE: begin
            stall    = mem_op;
            outValid = valid & ~mem_op;
            if (mem_op) state_nx = misalign ? DONE : REQ;
         end
         REQ: begin
            stall       = 1'b1;
            memReq      = 1'b1;
            memWe       = hold_wr & ~hold_rd;
            memAddr     = hold_addr;
            memWData    = hold_wdata;
            ALUDataOut  = hold_addr;
            memToRegOut = hold_m2r;
            regWriteOut = hold_rw;
            writeRegOut = hold_wreg;
            if (memAck || timeout_hit) state_nx = DONE;
         end
         DONE: begin
            outValid    = 1'b1;
            memData     = hold_data;
            memErr      = err_hold;
            ALUDataOut  = hold_addr;
            memToRegOut = hold_m2r;
            regWriteOut = hold_rw & ~err_hold;
            writeRegOut = hold_wreg;
            state_nx    = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end
endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed vector table, reset-in-flight sequence, random ops vs a behavioural model.
module tb_mem_stage;
   localparam int T = 15;

   logic        clk = 1'b0, rst = 1'b1;
   logic        valid = 0, memRead = 0, memWrite = 0, memToReg = 0, regWrite = 0, memAck = 0;
   logic [15:0] ALUData = 0, wrData = 0, memRData = 0;
   logic [2:0]  writeReg = 0;
   logic        stall, outValid, memToRegOut, regWriteOut, memErr, memReq, memWe;
   logic [15:0] memData, ALUDataOut, memAddr, memWData;
   logic [2:0]  writeRegOut;

   int n_chk = 0, n_fail = 0;

   mem_stage dut (
      .clk(clk), .rst(rst), .valid(valid), .ALUData(ALUData), .wrData(wrData),
      .memRead(memRead), .memWrite(memWrite), .memToReg(memToReg), .regWrite(regWrite),
      .writeReg(writeReg), .stall(stall), .outValid(outValid), .memData(memData),
      .ALUDataOut(ALUDataOut), .memToRegOut(memToRegOut), .regWriteOut(regWriteOut),
      .writeRegOut(writeRegOut), .memErr(memErr), .memReq(memReq), .memWe(memWe),
      .memAddr(memAddr), .memWData(memWData), .memAck(memAck), .memRData(memRData)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        valid, rd, wr, m2r, rw;
      logic [15:0] alu, wd, rdata;
      logic [2:0]  wreg;
      int          ack_at;
      int          e_stall, e_req;
      logic        e_out, e_err, e_rw, e_we;
      logic [15:0] e_data;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Expected outcome from the access rules: ack within TIMEOUT REQ cycles completes, else error.
   function automatic vec_t model(input vec_t v);
      vec_t r = v;
      logic acked, odd;
`ifdef ALIGN_CHECK_EN
      odd = v.alu[0];
`else
      odd = 1'b0;
`endif
      r.e_out = v.valid; r.e_we = v.wr & ~v.rd;
      if (!(v.valid && (v.rd || v.wr))) begin
         r.e_stall = 0; r.e_req = 0; r.e_err = 0; r.e_rw = v.rw; r.e_data = 0;
      end else if (odd) begin
         r.e_stall = 1; r.e_req = 0; r.e_err = 1; r.e_rw = 0; r.e_data = 0;
      end else begin
         acked     = (v.ack_at >= 1 && v.ack_at <= T);
         r.e_req   = acked ? v.ack_at : T;
         r.e_stall = r.e_req + 1;
         r.e_err   = !acked;
         r.e_rw    = v.rw & acked;
         r.e_data  = (v.rd && acked) ? v.rdata : 16'h0;
      end
      return r;
   endfunction

   task automatic run_vec(input vec_t v, input string tag);
      int  stalls = 0, reqs = 0, cyc = 0, budget;
      bit  got = 0, bus_ok = 1;
      logic [15:0] d_data = 0, d_alu = 0;
      logic [2:0]  d_wreg = 0;
      logic        d_err = 0, d_rw = 0, d_m2r = 0;
      budget = v.valid ? 40 : 1;
      @(negedge clk);
      valid = v.valid; memRead = v.rd; memWrite = v.wr; memToReg = v.m2r; regWrite = v.rw;
      ALUData = v.alu; wrData = v.wd; writeReg = v.wreg;
      while (!got && cyc < budget) begin
         #1;
         if (memReq) begin
            reqs++;
            memAck = (reqs == v.ack_at);
         end else begin
            memAck = 1'($urandom_range(0, 1));
         end
         memRData = (memReq && memAck) ? v.rdata : 16'($urandom);
         #1;
         if (memReq && (memWe !== v.e_we || memAddr !== v.alu || memWData !== v.wd)) bus_ok = 0;
         if (stall) stalls++;
         if (outValid) begin
            got = 1; d_data = memData; d_alu = ALUDataOut; d_wreg = writeRegOut;
            d_err = memErr; d_rw = regWriteOut; d_m2r = memToRegOut;
         end
         cyc++;
         if (!got && cyc < budget) @(negedge clk);
      end
      memAck = 0;
      chk({tag, " out_valid"}, 32'(got), 32'(v.e_out));
      chk({tag, " stall_cycles"}, stalls, v.e_stall);
      chk({tag, " req_cycles"}, reqs, v.e_req);
      if (v.e_req > 0) chk({tag, " req_bus"}, 32'(bus_ok), 32'd1);
      if (v.e_out) begin
         chk({tag, " mem_data"}, d_data, v.e_data);
         chk({tag, " mem_err"}, d_err, v.e_err);
         chk({tag, " reg_write"}, d_rw, v.e_rw);
         chk({tag, " alu_out"}, d_alu, v.alu);
         chk({tag, " write_reg"}, d_wreg, v.wreg);
         chk({tag, " mem_to_reg"}, d_m2r, v.m2r);
      end
   endtask

   vec_t tbl[9];
   vec_t rv;

   initial begin
      //          valid rd wr m2r rw  alu       wd        rdata     wreg ack  stall req out err rw we data
      tbl[0] = '{1, 0, 0, 0, 1, 16'h1234, 16'h0000, 16'h0000, 3'd3, 0,  0,  0,  1, 0, 1, 0, 16'h0000};
      tbl[1] = '{1, 1, 0, 1, 1, 16'h0040, 16'h0000, 16'hBEEF, 3'd5, 1,  2,  1,  1, 0, 1, 0, 16'hBEEF};
      tbl[2] = '{1, 0, 1, 0, 0, 16'h0010, 16'h00A5, 16'h0000, 3'd0, 4,  5,  4,  1, 0, 0, 1, 16'h0000};
      tbl[3] = '{1, 1, 0, 1, 1, 16'h0020, 16'h0000, 16'h0000, 3'd2, 0,  16, 15, 1, 1, 0, 0, 16'h0000};
      tbl[4] = '{1, 1, 0, 1, 1, 16'h0020, 16'h0000, 16'h1357, 3'd2, 15, 16, 15, 1, 0, 1, 0, 16'h1357};
`ifdef ALIGN_CHECK_EN
      tbl[5] = '{1, 1, 0, 1, 1, 16'h0041, 16'h0000, 16'hCAFE, 3'd6, 2,  1,  0,  1, 1, 0, 0, 16'h0000};
`else
      tbl[5] = '{1, 1, 0, 1, 1, 16'h0041, 16'h0000, 16'hCAFE, 3'd6, 2,  3,  2,  1, 0, 1, 0, 16'hCAFE};
`endif
      tbl[6] = '{0, 1, 0, 1, 1, 16'h0050, 16'h0000, 16'h0000, 3'd1, 1,  0,  0,  0, 0, 1, 0, 16'h0000};
      tbl[7] = '{1, 1, 1, 0, 1, 16'h0030, 16'hFFFF, 16'h4242, 3'd7, 3,  4,  3,  1, 0, 1, 0, 16'h4242};
      tbl[8] = '{1, 0, 1, 0, 1, 16'h0072, 16'h5A5A, 16'h0000, 3'd4, 0,  16, 15, 1, 1, 0, 1, 16'h0000};

      #3;
      chk("rst stall", stall, 0);
      chk("rst out_valid", outValid, 0);
      chk("rst mem_req", memReq, 0);
      chk("rst mem_err", memErr, 0);
      chk("rst mem_addr", memAddr, 0);
      valid = 1; memRead = 1; #1;
      chk("rst stall_follows_memop", stall, 1);
      chk("rst mem_req_load", memReq, 0);
      valid = 0; memRead = 0;
      @(negedge clk); rst = 0;

      for (int i = 0; i < 9; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

      // Reset lands in the second REQ cycle of a load that never gets acked
      @(negedge clk);
      valid = 1; memRead = 1; memWrite = 0; ALUData = 16'h0040; memAck = 0;
      @(negedge clk); #1;
      chk("inflight req_cycle1", memReq, 1);
      @(negedge clk);
      chk("inflight req_cycle2", memReq, 1);
      rst = 1; #1;
      chk("inflight rst mem_req", memReq, 0);
      chk("inflight rst stall", stall, 1);
      chk("inflight rst out_valid", outValid, 0);
      chk("inflight rst mem_addr", memAddr, 0);
      valid = 0; #1;
      chk("inflight rst stall_idle", stall, 0);
      @(negedge clk); rst = 0;
      run_vec(tbl[1], "after_rst");

      for (int i = 0; i < 40; i++) begin
         rv.valid = ($urandom_range(0, 9) != 0);
         rv.rd = 1'($urandom_range(0, 1)); rv.wr = 1'($urandom_range(0, 1));
         rv.m2r = 1'($urandom_range(0, 1)); rv.rw = 1'($urandom_range(0, 1));
         rv.alu = 16'($urandom); rv.wd = 16'($urandom); rv.rdata = 16'($urandom);
         rv.wreg = 3'($urandom); rv.ack_at = $urandom_range(0, T + 2);
         run_vec(model(rv), $sformatf("rand%0d", i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
